// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage for the multi-cycle MIPS core. It holds the PC, runs a
//   req/ack handshake to instruction memory, presents the fetched word to the
//   main control decoder, and picks the next PC when execute commits. Only one
//   instruction is in flight at a time. The unit also counts retired
//   instructions.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          asynchronous, active-low reset
//   imem_req_o     fetch request; held high until imem_ack_i
//   imem_addr_o    fetch address (always equal to pc_o)
//   imem_ack_i     memory returns imem_rdata_i this cycle
//   imem_rdata_i   instruction word, valid with imem_ack_i
//   instr_o        latched instruction (op = [31:26], funct = [5:0])
//   instr_valid_o  instr_o holds the current instruction
//   pc_o           PC of the current instruction
//   pc_plus4_o     pc_o + 4 (jal link value)
//   commit_i       execute finished; next-PC inputs are valid
//   Jump_i         00 j/jal, 01 sequential/branch, 10 jr, 11 same as 01
//   Branch_i       instruction is a conditional branch
//   BranchType_i   00 beq, 01 ble, 10 blt, 11 bne
//   zero_i         ALU result is zero
//   neg_i          ALU result MSB
//   imm_sext_i     sign-extended 16-bit immediate
//   rs_data_i      register rs value (jr target)
//   misalign_o     sticky: a jr target had nonzero low bits
//   retired_o      number of committed instructions (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  input  logic             commit_i,
  input  logic [1:0]       Jump_i,
  input  logic             Branch_i,
  input  logic [1:0]       BranchType_i,
  input  logic             zero_i,
  input  logic             neg_i,
  input  logic [31:0]      imm_sext_i,
  input  logic [31:0]      rs_data_i,
  output logic             misalign_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              misalign_q;
  logic [CNT_W-1:0]  retired_q;

  logic [31:0]       pc_plus4;
  logic [31:0]       br_off;
  logic              br_taken;
  logic [31:0]       next_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = imm_sext_i << 2;

  always_comb begin
    br_taken = 1'b0;
    unique case (BranchType_i)
      2'b00: br_taken = zero_i;
      2'b01: br_taken = zero_i | neg_i;
      2'b10: br_taken = neg_i;
      2'b11: br_taken = ~zero_i;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    unique case (Jump_i)
      2'b00:   next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b10:   next_pc = {rs_data_i[31:2], 2'b00};
      default: next_pc = (Branch_i && br_taken) ? (pc_plus4 + br_off) : pc_plus4;
    endcase
  end

  // The request is a register so it stays low throughout reset even though
  // the state resets to FETCH; it rises on the first edge after release and
  // on the edge that accepts a commit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (commit_i) begin
            pc_q      <= next_pc;
            valid_q   <= 1'b0;
            retired_q <= retired_q + CNT_W'(1);
            req_q     <= 1'b1;
            state_q   <= FETCH;
            if (Jump_i == 2'b10 && rs_data_i[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign misalign_o    = misalign_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Bench for instr_fetch_unit. A reference model of the PC/retired/misalign
//   state predicts each next fetch address and pushes it to a scoreboard
//   queue when a commit is driven; the address is popped and compared when
//   the DUT raises its next fetch request.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned CW     = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_ack_i;
  logic [31:0]   imem_rdata_i;
  logic [31:0]   instr_o;
  logic          instr_valid_o;
  logic [31:0]   pc_o;
  logic [31:0]   pc_plus4_o;
  logic          commit_i;
  logic [1:0]    Jump_i;
  logic          Branch_i;
  logic [1:0]    BranchType_i;
  logic          zero_i;
  logic          neg_i;
  logic [31:0]   imm_sext_i;
  logic [31:0]   rs_data_i;
  logic          misalign_o;
  logic [CW-1:0] retired_o;

  instr_fetch_unit #(
    .RESET_PC (RST_PC),
    .CNT_W    (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .commit_i      (commit_i),
    .Jump_i        (Jump_i),
    .Branch_i      (Branch_i),
    .BranchType_i  (BranchType_i),
    .zero_i        (zero_i),
    .neg_i         (neg_i),
    .imm_sext_i    (imm_sext_i),
    .rs_data_i     (rs_data_i),
    .misalign_o    (misalign_o),
    .retired_o     (retired_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;
  logic        m_mis;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = '0;
    m_ret   = '0;
    m_mis   = 1'b0;
    exp_addr_q.delete();
    exp_addr_q.push_back(RST_PC);
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    imem_ack_i   = 1'b0;
    imem_rdata_i = '0;
    commit_i     = 1'b0;
    Jump_i       = 2'b01;
    Branch_i     = 1'b0;
    BranchType_i = 2'b00;
    zero_i       = 1'b0;
    neg_i        = 1'b0;
    imm_sext_i   = '0;
    rs_data_i    = '0;
    repeat (2) @(negedge clk_i);
    check("rst_req",      {31'b0, imem_req_o},    32'd0);
    check("rst_valid",    {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr",    instr_o,                32'd0);
    check("rst_pc",       pc_o,                   RST_PC);
    check("rst_misalign", {31'b0, misalign_o},    32'd0);
    check("rst_retired",  32'(retired_o),         32'd0);
    model_reset();
    rst_i = 1'b1;
  endtask

  // Wait for the request, compare its address with the scoreboard, hold ack
  // off for lat cycles (optionally pulsing a stray commit), then ack.
  task automatic fetch(input logic [31:0] word, input int lat, input bit poke_commit);
    logic [31:0] e;
    wait_req();
    check("req_seen", {31'b0, imem_req_o}, 32'd1);
    if (imem_req_o !== 1'b1) return;
    check("sb_nonempty", {31'b0, exp_addr_q.size() != 0}, 32'd1);
    if (exp_addr_q.size() == 0) return;
    e = exp_addr_q.pop_front();
    check("fetch_addr", imem_addr_o, e);
    m_pc = e;
    for (int i = 0; i < lat; i++) begin
      if (poke_commit && i == 0) commit_i = 1'b1;
      @(negedge clk_i);
      commit_i = 1'b0;
      check("req_held",  {31'b0, imem_req_o}, 32'd1);
      check("addr_held", imem_addr_o,         e);
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = word;
    @(negedge clk_i);
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    m_instr      = word;
    check("instr",       instr_o,                word);
    check("instr_valid", {31'b0, instr_valid_o}, 32'd1);
    check("pc",          pc_o,                   m_pc);
    check("pc_plus4",    pc_plus4_o,             m_pc + 32'd4);
    check("req_dropped", {31'b0, imem_req_o},    32'd0);
    check("retired_f",   32'(retired_o),         m_ret);
  endtask

  task automatic commit(input logic [1:0] jump, input logic br, input logic [1:0] bt,
                        input logic z, input logic n, input logic [31:0] imm,
                        input logic [31:0] rs, input bit spurious);
    logic [31:0] p4;
    logic [31:0] np;
    logic        take;
    if (spurious) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = ~m_instr;
      @(negedge clk_i);
      imem_ack_i   = 1'b0;
      check("spur_instr", instr_o,                m_instr);
      check("spur_req",   {31'b0, imem_req_o},    32'd0);
      check("spur_valid", {31'b0, instr_valid_o}, 32'd1);
      check("spur_pc",    pc_o,                   m_pc);
    end
    p4 = m_pc + 32'd4;
    case (bt)
      2'b00:   take = z;
      2'b01:   take = z || n;
      2'b10:   take = n;
      default: take = !z;
    endcase
    if (jump == 2'b00) begin
      np = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    end else if (jump == 2'b10) begin
      np = rs & 32'hFFFF_FFFC;
      if ((rs & 32'd3) != 0) m_mis = 1'b1;
    end else begin
      np = (br && take) ? p4 + imm * 4 : p4;
    end
    exp_addr_q.push_back(np);
    m_ret = (m_ret + 1) % (32'd1 << CW);
    Jump_i       = jump;
    Branch_i     = br;
    BranchType_i = bt;
    zero_i       = z;
    neg_i        = n;
    imm_sext_i   = imm;
    rs_data_i    = rs;
    commit_i     = 1'b1;
    @(negedge clk_i);
    commit_i = 1'b0;
    check("cmt_valid",    {31'b0, instr_valid_o}, 32'd0);
    check("cmt_retired",  32'(retired_o),         m_ret);
    check("cmt_misalign", {31'b0, misalign_o},    {31'b0, m_mis});
    check("cmt_req",      {31'b0, imem_req_o},    32'd1);
    check("cmt_pc",       pc_o,                   np);
  endtask

  initial begin
    do_reset();
    // reset release, ack two cycles after the first request
    fetch(32'h2008_0005, 2, 1'b0);
    commit(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // -> 0x04
    fetch(32'h0800_0004, 0, 1'b0);
    commit(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // j -> 0x10
    // beq taken backwards
    fetch(32'h1000_FFFE, 1, 1'b0);
    commit(2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0, 1'b0); // -> 0x0C
    fetch(32'h0800_0004, 0, 1'b0);
    commit(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // -> 0x10
    // beq not taken
    fetch(32'h1000_FFFE, 0, 1'b0);
    commit(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0, 1'b0); // -> 0x14
    fetch(32'h0800_0004, 0, 1'b0);
    commit(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // -> 0x10
    // bne taken
    fetch(32'h1400_FFFE, 0, 1'b0);
    commit(2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0, 1'b0); // -> 0x0C
    // stray commit in FETCH, spurious ack in HOLD, aligned jr
    fetch(32'h0000_0008, 2, 1'b1);
    commit(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'h4000_0008, 1'b1); // -> 0x4000_0008
    // jal within the upper PC region
    fetch(32'h0C00_0040, 0, 1'b0);
    commit(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // -> 0x4000_0100
    // misaligned jr
    fetch(32'h0000_0008, 0, 1'b0);
    commit(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'h0000_0102, 1'b0); // -> 0x100
    // blt taken, ble not taken (Jump=11), ble taken via neg
    fetch(32'h0800_0000, 1, 1'b0);
    commit(2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);      // -> 0x114
    fetch(32'h0800_0000, 0, 1'b0);
    commit(2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 32'd8, 32'd0, 1'b0);      // -> 0x118
    fetch(32'h0800_0000, 0, 1'b0);
    commit(2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0); // -> 0x118
    // PC wrap at the top of the address space
    fetch(32'h0000_0008, 0, 1'b0);
    commit(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC, 1'b0); // -> 0xFFFF_FFFC
    fetch(32'h0000_0000, 0, 1'b0);
    commit(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // -> 0x0
    fetch(32'h0000_0008, 0, 1'b0);
    commit(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'h0000_0020, 1'b0); // -> 0x20

    // async reset while fetching from 0x20
    wait_req();
    check("req_0x20", {31'b0, imem_req_o}, 32'd1);
    if (exp_addr_q.size() != 0) check("fetch_addr_0x20", imem_addr_o, exp_addr_q.pop_front());
    #2 rst_i = 1'b0;
    #1;
    check("arst_req",      {31'b0, imem_req_o},    32'd0);
    check("arst_valid",    {31'b0, instr_valid_o}, 32'd0);
    check("arst_retired",  32'(retired_o),         32'd0);
    check("arst_misalign", {31'b0, misalign_o},    32'd0);
    @(negedge clk_i);
    model_reset();
    rst_i = 1'b1;
    fetch(32'h2008_0005, 1, 1'b0);

    // async reset while holding an instruction
    #2 rst_i = 1'b0;
    #1;
    check("arst_hold_valid", {31'b0, instr_valid_o}, 32'd0);
    check("arst_hold_instr", instr_o,                32'd0);
    @(negedge clk_i);
    model_reset();
    rst_i = 1'b1;
    fetch(32'h0800_0004, 0, 1'b0);
    commit(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);      // -> 0x10
    fetch(32'h0000_0000, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
